// File: rtl/tcp_rx_ack_proc.sv
// tcp_rx_ack_proc: receive-side ACK/window/payload processing for one TCP flow
// per transaction. Reads the flow's RX and TX state, computes the updated RX
// state, writes it back, optionally commits in-order payload and issues one
// scheduler update command.
//
// Optional feature macro: TCP_RX_FAST_RT_EN (duplicate-ACK counting and fast
// retransmit). Undefined: dup_cnt is always written as 0 and rt_pend is NOP.
//
// Handshakes: a transfer happens on a rising clk edge where val and rdy are
// both 1. Once val is raised it stays high, with its payload/command held
// stable, until that transfer. rx_state_wr_req_val is a one-cycle strobe with
// no ready.

`ifndef FLAGS_W
`define FLAGS_W 8
`endif

package tcp_rx_ack_proc_pkg;
  localparam int FLOWID_W         = 4;
  localparam int TX_PAYLOAD_PTR_W = 11;

  // TCP flag bit positions inside rx_pkt_flags
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_ACK = 4;

  typedef enum logic [1:0] {
    SCHED_NOP = 2'd0,
    SCHED_SET = 2'd1,
    SCHED_CLR = 2'd2
  } sched_op_e;

  typedef struct packed {
    logic [31:0] ack_num;
    logic [7:0]  dup_cnt;
  } ack_state_struct;

  typedef struct packed {
    ack_state_struct our_ack_state;
    logic [31:0]     their_ack_num;
    logic [15:0]     their_win_size;
    logic [15:0]     our_win_size;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [31:0] our_seq_num;
  } smol_tx_state_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    sched_op_e           ack_pend;
    sched_op_e           data_pend;
    sched_op_e           rt_pend;
    logic [31:0]         ack_timestamp;
    logic [31:0]         rt_timestamp;
  } sched_cmd_struct;
endpackage

module tcp_rx_ack_proc
  import tcp_rx_ack_proc_pkg::*;
#(
  parameter int RD_LAT         = 1,
  parameter int DUP_ACK_THRESH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_pkt_val,
  output logic                        rx_pkt_rdy,
  input  logic [FLOWID_W-1:0]         rx_pkt_flowid,
  input  logic [31:0]                 rx_pkt_seq_num,
  input  logic [31:0]                 rx_pkt_ack_num,
  input  logic [`FLAGS_W-1:0]         rx_pkt_flags,
  input  logic [15:0]                 rx_pkt_window,
  input  logic [TX_PAYLOAD_PTR_W:0]   rx_pkt_payload_len,
  output logic [FLOWID_W-1:0]         rx_state_rd_req_addr,
  input  smol_rx_state_struct         rx_state_rd_resp_data,
  output logic [FLOWID_W-1:0]         tx_state_rd_req_addr,
  input  smol_tx_state_struct         tx_state_rd_resp_data,
  output logic                        rx_state_wr_req_val,
  output logic [FLOWID_W-1:0]         rx_state_wr_req_addr,
  output smol_rx_state_struct         rx_state_wr_req_data,
  output logic                        payload_commit_val,
  input  logic                        payload_commit_rdy,
  output logic [TX_PAYLOAD_PTR_W:0]   payload_commit_len,
  output logic                        sched_update_val,
  input  logic                        sched_update_rdy,
  output sched_cmd_struct             sched_update_cmd,
  output logic [2:0]                  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_CALC    = 3'd2,
    S_WRITE   = 3'd3,
    S_COMMIT  = 3'd4,
    S_SCHED   = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic                      rdy_q;
  logic [1:0]                rd_cnt_q;
  logic                      rd_last;
  logic [FLOWID_W-1:0]       flowid_q;
  logic [31:0]               seq_q;
  logic [31:0]               ack_q;
  logic                      ack_f_q;
  logic                      ctl_f_q;
  logic [15:0]               win_q;
  logic [TX_PAYLOAD_PTR_W:0] len_q;
  smol_rx_state_struct       rx_q;
  smol_tx_state_struct       tx_q;
  smol_rx_state_struct       new_rx_q, new_rx_d;
  logic                      accept_q, accept_d;
  logic                      new_ack_q, new_ack_d;
  logic                      fast_rt_q, fast_rt_d;
  logic [31:0]               ack_adv;
  logic [31:0]               outstanding;
  logic                      pkt_fire;

  assign pkt_fire = (state_q == S_IDLE) && rx_pkt_val && rdy_q;
  assign rd_last  = (rd_cnt_q == 2'(RD_LAT - 1));

  // State register; rdy is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == S_IDLE);
    end
  end

  // Next-state logic: one packet walks the full state sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pkt_fire) state_d = S_RD_WAIT;
      S_RD_WAIT: if (rd_last) state_d = S_CALC;
      S_CALC:    state_d = S_WRITE;
      S_WRITE:   state_d = accept_q ? S_COMMIT : S_SCHED;
      S_COMMIT:  if (payload_commit_rdy) state_d = S_SCHED;
      S_SCHED:   if (sched_update_rdy) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Capture registers: packet fields, read responses and computed results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q  <= '0;
      flowid_q  <= '0;
      seq_q     <= '0;
      ack_q     <= '0;
      ack_f_q   <= 1'b0;
      ctl_f_q   <= 1'b0;
      win_q     <= '0;
      len_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      new_rx_q  <= '0;
      accept_q  <= 1'b0;
      new_ack_q <= 1'b0;
      fast_rt_q <= 1'b0;
    end else begin
      if (pkt_fire) begin
        flowid_q <= rx_pkt_flowid;
        seq_q    <= rx_pkt_seq_num;
        ack_q    <= rx_pkt_ack_num;
        ack_f_q  <= rx_pkt_flags[FLAG_ACK];
        ctl_f_q  <= rx_pkt_flags[FLAG_SYN] | rx_pkt_flags[FLAG_FIN] |
                    rx_pkt_flags[FLAG_RST];
        win_q    <= rx_pkt_window;
        len_q    <= rx_pkt_payload_len;
      end
      rd_cnt_q <= (state_q == S_RD_WAIT) ? rd_cnt_q + 2'd1 : 2'd0;
      if ((state_q == S_RD_WAIT) && rd_last) begin
        rx_q <= rx_state_rd_resp_data;
        tx_q <= tx_state_rd_resp_data;
      end
      if (state_q == S_CALC) begin
        new_rx_q  <= new_rx_d;
        accept_q  <= accept_d;
        new_ack_q <= new_ack_d;
        fast_rt_q <= fast_rt_d;
      end
    end
  end

  // ACK / window / payload rules, evaluated from the latched packet and state
  always_comb begin
    ack_adv     = ack_q - rx_q.our_ack_state.ack_num;
    outstanding = tx_q.our_seq_num - rx_q.our_ack_state.ack_num;
    new_ack_d   = ack_f_q && (ack_adv != 32'd0) && (ack_adv <= outstanding);
    accept_d    = (len_q != '0) && !ctl_f_q && (seq_q == rx_q.their_ack_num) &&
                  (16'(len_q) <= rx_q.our_win_size);
    fast_rt_d   = 1'b0;
    new_rx_d    = rx_q;
    if (ack_f_q) new_rx_d.their_win_size = win_q;
    if (new_ack_d) new_rx_d.our_ack_state.ack_num = ack_q;
`ifdef TCP_RX_FAST_RT_EN
    if (new_ack_d) begin
      new_rx_d.our_ack_state.dup_cnt = 8'd0;
    end else if (ack_f_q && (ack_q == rx_q.our_ack_state.ack_num) &&
                 (len_q == '0) && (win_q == rx_q.their_win_size) &&
                 (tx_q.our_seq_num != rx_q.our_ack_state.ack_num)) begin
      // duplicate ACK: count up, saturating, and fire once at the threshold
      if (rx_q.our_ack_state.dup_cnt < 8'(DUP_ACK_THRESH)) begin
        new_rx_d.our_ack_state.dup_cnt = rx_q.our_ack_state.dup_cnt + 8'd1;
        fast_rt_d = (rx_q.our_ack_state.dup_cnt + 8'd1 == 8'(DUP_ACK_THRESH));
      end else begin
        new_rx_d.our_ack_state.dup_cnt = 8'(DUP_ACK_THRESH);
      end
    end else if (ack_f_q) begin
      new_rx_d.our_ack_state.dup_cnt = 8'd0;
    end
`else
    new_rx_d.our_ack_state.dup_cnt = 8'd0;
`endif
    if (accept_d) new_rx_d.their_ack_num = rx_q.their_ack_num + 32'(len_q);
  end

  // Flag bits that carry no meaning for this block
  logic unused_sig;
`ifdef TCP_RX_FAST_RT_EN
  assign unused_sig = ^{rx_pkt_flags[`FLAGS_W-1:5], rx_pkt_flags[3]};
`else
  assign unused_sig = ^{rx_pkt_flags[`FLAGS_W-1:5], rx_pkt_flags[3],
                        rx_q.our_ack_state.dup_cnt, 8'(DUP_ACK_THRESH)};
`endif

  // Outputs are decoded from the state and the held capture registers
  always_comb begin
    rx_pkt_rdy                     = rdy_q;
    rx_state_rd_req_addr           = flowid_q;
    tx_state_rd_req_addr           = flowid_q;
    rx_state_wr_req_val            = (state_q == S_WRITE);
    rx_state_wr_req_addr           = flowid_q;
    rx_state_wr_req_data           = new_rx_q;
    payload_commit_val             = (state_q == S_COMMIT);
    payload_commit_len             = len_q;
    sched_update_val               = (state_q == S_SCHED);
    sched_update_cmd               = '0;
    sched_update_cmd.flowid        = flowid_q;
    sched_update_cmd.ack_pend      = (len_q != '0) ? SCHED_SET : SCHED_NOP;
    sched_update_cmd.data_pend     = new_ack_q ? SCHED_SET : SCHED_NOP;
    sched_update_cmd.rt_pend       = fast_rt_q ? SCHED_SET : SCHED_NOP;
    dbg_state_o                    = state_q;
  end

endmodule
